// File: rtl/cronometro_pkg.sv
// -----------------------------------------------------------------------------
// cronometro_pkg
// Shared definitions for the stopwatch digit stages:
//   - state_t      : run/hold/stop control FSM encoding
//   - BCD_MAX      : largest legal BCD digit value
//   - SEG_*        : 7-segment patterns, bit order {a,b,c,d,e,f,g}, active-high
// No ports (package).
// -----------------------------------------------------------------------------
package cronometro_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Segment patterns: bit 6 = a ... bit 0 = g
    localparam logic [6:0] SEG_0     = 7'b1111110; // abcdef
    localparam logic [6:0] SEG_1     = 7'b0110000; // bc
    localparam logic [6:0] SEG_2     = 7'b1101101; // abdeg
    localparam logic [6:0] SEG_3     = 7'b1111001; // abcdg
    localparam logic [6:0] SEG_4     = 7'b0110011; // bcfg
    localparam logic [6:0] SEG_5     = 7'b1011011; // acdfg
    localparam logic [6:0] SEG_6     = 7'b1011111; // acdefg
    localparam logic [6:0] SEG_7     = 7'b1110000; // abc
    localparam logic [6:0] SEG_8     = 7'b1111111; // all
    localparam logic [6:0] SEG_9     = 7'b1111011; // abcdfg
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_dec.sv
// -----------------------------------------------------------------------------
// seg7_dec
// Combinational BCD to 7-segment decoder shared by all digit stages.
// Values above 9 blank every segment.
// Ports:
//   bcd_i  in  4  BCD digit
//   seg_o  out 7  segment drive {a,b,c,d,e,f,g}, active-high
// -----------------------------------------------------------------------------
module seg7_dec
    import cronometro_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/unid_min.sv
// -----------------------------------------------------------------------------
// unid_min
// Units-of-minutes digit of the stopwatch. Holds a BCD digit that counts up or
// down on TICK while in RUN, emits a registered one-cycle CARRY (9->0, up) or
// BORROW (0->9, down), and owns the STOP/RUN/HOLD control FSM driven by the
// rising edge of START, plus CLR and LOAD.
//
// Optional build macro: UNID_MIN_SYNC_EN
//   defined   -> START, CLR, LOAD each pass a 2-flop synchronizer (+2 cycles)
//   undefined -> those inputs are used directly
//
// Ports:
//   CLK          in   1  clock, rising edge
//   RST          in   1  synchronous active-high reset
//   TICK         in   1  count event from the tens-of-seconds stage
//   START        in   1  start/stop button level (rising edge acts)
//   CLR          in   1  clear digit, return to STOP
//   LOAD         in   1  load LOAD_VAL (clamped to 9) in STOP/HOLD
//   LOAD_VAL     in   4  preset value
//   UP           in   1  1 = count up, 0 = count down
//   DIGIT        out  4  current BCD value
//   CARRY        out  1  one-cycle pulse on 9->0 counting up
//   BORROW       out  1  one-cycle pulse on 0->9 counting down
//   RUNNING      out  1  high in RUN
//   aum..gum     out  1  7-segment drive of DIGIT, active-high
//   state_dbg_o  out  2  current FSM state (debug observation)
//
// Handshake: none; TICK is a single-cycle strobe, acted on only in RUN and
// never queued. CARRY/BORROW are single-cycle strobes to the next stage.
// -----------------------------------------------------------------------------
module unid_min
    import cronometro_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK,
    input  logic       START,
    input  logic       CLR,
    input  logic       LOAD,
    input  logic [3:0] LOAD_VAL,
    input  logic       UP,
    output logic [3:0] DIGIT,
    output logic       CARRY,
    output logic       BORROW,
    output logic       RUNNING,
    output logic       aum,
    output logic       bum,
    output logic       cum,
    output logic       dum,
    output logic       eum,
    output logic       fum,
    output logic       gum,
    output state_t     state_dbg_o
);

    // -------------------------------------------------------------------------
    // Control input conditioning
    // -------------------------------------------------------------------------
    logic start_s;
    logic clr_s;
    logic load_s;

`ifdef UNID_MIN_SYNC_EN
    logic [1:0] start_sync_q;
    logic [1:0] clr_sync_q;
    logic [1:0] load_sync_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            start_sync_q <= 2'b00;
            clr_sync_q   <= 2'b00;
            load_sync_q  <= 2'b00;
        end else begin
            start_sync_q <= {start_sync_q[0], START};
            clr_sync_q   <= {clr_sync_q[0], CLR};
            load_sync_q  <= {load_sync_q[0], LOAD};
        end
    end

    assign start_s = start_sync_q[1];
    assign clr_s   = clr_sync_q[1];
    assign load_s  = load_sync_q[1];
`else
    assign start_s = START;
    assign clr_s   = CLR;
    assign load_s  = LOAD;
`endif

    // -------------------------------------------------------------------------
    // START rising-edge detector
    // -------------------------------------------------------------------------
    logic start_prev_q;
    logic start_edge;

    always_ff @(posedge CLK) begin
        if (RST) start_prev_q <= 1'b0;
        else     start_prev_q <= start_s;
    end

    assign start_edge = start_s & ~start_prev_q;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   load_eff;
    logic   count_en;

    // LOAD only acts outside RUN; when it acts it outranks a START edge.
    assign load_eff = load_s && (state_q != ST_RUN);
    // TICK is judged in the pre-transition state, so a START edge in RUN
    // still lets the coincident tick count.
    assign count_en = TICK && (state_q == ST_RUN);

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_STOP;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr_s) begin
            state_d = ST_STOP;
        end else if (load_eff) begin
            state_d = state_q;
        end else if (start_edge) begin
            case (state_q)
                ST_STOP: state_d = ST_RUN;
                ST_RUN:  state_d = ST_HOLD;
                ST_HOLD: state_d = ST_RUN;
                default: state_d = ST_STOP;
            endcase
        end
    end

    always_comb begin
        RUNNING     = (state_q == ST_RUN);
        state_dbg_o = state_q;
    end

    // -------------------------------------------------------------------------
    // BCD counter with registered carry/borrow
    // -------------------------------------------------------------------------
    logic [3:0] digit_q;
    logic [3:0] digit_d;
    logic       carry_q;
    logic       carry_d;
    logic       borrow_q;
    logic       borrow_d;

    always_comb begin
        digit_d  = digit_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (clr_s) begin
            digit_d = 4'd0;
        end else if (load_eff) begin
            digit_d = (LOAD_VAL > BCD_MAX) ? BCD_MAX : LOAD_VAL;
        end else if (count_en) begin
            if (UP) begin
                if (digit_q >= BCD_MAX) begin
                    digit_d = 4'd0;
                    carry_d = 1'b1;
                end else begin
                    digit_d = digit_q + 4'd1;
                end
            end else begin
                if (digit_q == 4'd0) begin
                    digit_d  = BCD_MAX;
                    borrow_d = 1'b1;
                end else begin
                    digit_d = digit_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            digit_q  <= 4'd0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            digit_q  <= digit_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign DIGIT  = digit_q;
    assign CARRY  = carry_q;
    assign BORROW = borrow_q;

    // -------------------------------------------------------------------------
    // Segment drive, straight from the digit register
    // -------------------------------------------------------------------------
    logic [6:0] seg;

    seg7_dec u_seg7_dec (
        .bcd_i (digit_q),
        .seg_o (seg)
    );

    assign {aum, bum, cum, dum, eum, fum, gum} = seg;

endmodule
